// File: rtl/fib_seq_responder.sv
// fib_seq_responder: ready/done handshake responder computing fib(x) mod 2^RESULT_WIDTH
module fib_seq_responder #(
    parameter int ARG_WIDTH    = 8,
    parameter int RESULT_WIDTH = 8
) (
    input  logic                    CLOCK_50,
    input  logic                    RESET_N,
    input  logic                    ready,
    input  logic [ARG_WIDTH-1:0]    x,
    output logic                    done,
    output logic [RESULT_WIDTH-1:0] result,
    output logic                    busy
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t                  r_state;
    logic [ARG_WIDTH-1:0]    r_cnt;
    logic [RESULT_WIDTH-1:0] r_a;
    logic [RESULT_WIDTH-1:0] r_b;
    logic [RESULT_WIDTH-1:0] r_result;
    logic                    r_done;
    logic                    r_busy;
    assign done   = r_done;
    assign result = r_result;
    assign busy   = r_busy;
    // Handshake FSM and Fibonacci iteration; every output is a register
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_result <= '0;
            r_done   <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (ready) begin
                    r_cnt   <= x;
                    r_a     <= '0;
                    r_b     <= RESULT_WIDTH'(1);
                    r_busy  <= 1'b1;
                    r_state <= RUN;
                end
                RUN: if (!ready) begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end else if (r_cnt == '0) begin
                    r_result <= r_a;
                    r_done   <= 1'b1;
                    r_busy   <= 1'b0;
                    r_state  <= DONE;
                end else begin
                    r_a   <= r_b;
                    r_b   <= r_a + r_b;
                    r_cnt <= r_cnt - 1'b1;
                end
                DONE: if (!ready) begin
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/fib_seq_responder.md
# fib_seq_responder

Sequential Fibonacci responder on the ready/done request handshake that our generated function blocks expose to a driving controller. It latches an argument when the initiator raises `ready`, then iterates. It presents `fib(x) mod 2^RESULT_WIDTH` on `result` and asserts `done` until the initiator withdraws `ready`. It is the hand-written, resettable responder end of that handshake, used as a golden model and as a drop-in target for the board-level sweep controller.

## Interface
- `ARG_WIDTH`, 8: width of argument `x`; iteration count range is 0 .. 2^ARG_WIDTH-1.
- `RESULT_WIDTH`, 8: width of `result`; arithmetic wraps modulo 2^RESULT_WIDTH.

- `CLOCK_50`  in  1  sole clock; all state changes on its rising edge.
- `RESET_N`  in  1  asynchronous, active-low reset.
- `ready`  in  1  request from initiator; held high until `done` is seen, then dropped.
- `x`  in  ARG_WIDTH  argument; sampled only on the IDLE→RUN edge.
- `done`  out  1  result valid; registered.
- `result`  out  RESULT_WIDTH  Fibonacci value; registered, holds last value.
- `busy`  out  1  high in RUN state; registered.

## Operation
- Registers:
  - `state` ∈ {IDLE, RUN, DONE}.
  - `cnt` (ARG_WIDTH).
  - `a`, `b` (RESULT_WIDTH).
  - `result`.
- Reset (RESET_N low, asynchronous): state=IDLE, done=0, busy=0, result=0, cnt=0, a=0, b=0.
- IDLE:
  - If `ready`=1: cnt←x, a←0, b←1, busy←1; go RUN.
  - Else: stay.
- RUN, checked in this order:
  - If `ready`=0: abort. Go IDLE with busy←0; done stays 0; `result` is not updated.
  - Else if cnt=0: result←a, done←1, busy←0; go DONE.
  - Else: a←b, b←a+b (truncated to RESULT_WIDTH), cnt←cnt-1.
- DONE:
  - If `ready`=1: stay; done and result held.
  - If `ready`=0: done←0; go IDLE.
- Arithmetic:
  - fib(0)=0, fib(1)=1.
  - All additions wrap modulo 2^RESULT_WIDTH; there is no overflow flag.
- `x` changes are ignored outside the IDLE→RUN sampling edge.
- `ready` held high after `done` does not restart a computation. A new request requires `ready` low for at least one edge, so that the block returns to IDLE.

## Timing
- Edge E0: `ready` is first sampled high in IDLE, and the block enters RUN.
- `done` rises at edge E0+x+1 and is visible in the cycle after that edge, i.e. x+2 edges counting E0 as edge 1.
- Minimum latency: x=0 → done after 2 edges.
- Maximum latency: x=2^ARG_WIDTH-1 → 2^ARG_WIDTH+1 edges.
- `result` and `done` update on the same edge; result is valid whenever done=1.
- Handshake release: `done` falls on the first edge that samples ready=0 in DONE.
- Earliest re-request: ready is sampled high again at the next edge after the block reaches IDLE. Initiator turnaround is therefore done-high → ready-low → ready-high, 2 edges minimum.
- Reset asserted mid-RUN or in DONE: outputs clear immediately, with no dependency on the clock. Operation resumes from IDLE on the first edge after RESET_N rises.
- There are no combinational paths from inputs to outputs.

## Test plan
- Reset/idle: assert RESET_N=0 mid-RUN with x=10 → done=0, busy=0 and result=0 immediately. After release with ready=0 → state stays IDLE with outputs 0.
- Single requests:
  - x=0 → done after 2 edges, result=0.
  - x=1 → done after 3 edges, result=1.
  - x=10 → done after 12 edges, result=55.
- Wrap-around: x=13 → result=233. x=14 → result=121 (377 mod 256).
- Sweep mimicking the sweep controller:
  - Procedure: x = 0..20. Raise ready, wait for done, drop ready, increment x.
  - Each result must match a reference `fib(x) mod 256`.
  - done must fall on the edge after ready drops.
  - No request may be lost or double-serviced.
- Hold/ignore:
  - Setup: x=5 completes, then keep ready=1 for 10 edges while changing x to 9.
  - done stays 1 and result stays 5 throughout, with no restart.
  - After ready drops and then rises again, result=34.
- Abort: x=20, drop ready 5 edges after E0 → busy falls on the next edge, done never rises, and result keeps its previous value.
